trap_unit: RTL and testbench
============================

TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, PC/tval width.
REQ-002 SHALL have port clk_i input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i input 1: instruction in commit stage is valid this cycle.
REQ-005 SHALL have port cause_i input 6: raw trap flags. Bit 0 fetch error, 1 decode error, 2 mem-access error, 3 unknown branch type, 4 ECALL, 5 EBREAK.
REQ-006 SHALL have port pc_i input DATA_WIDTH: PC of committing instruction.
REQ-007 SHALL have port tval_i input DATA_WIDTH: faulting address/instruction word.
REQ-008 SHALL have port trap_ack_i input 1: monitor acknowledges the presented trap.
REQ-009 SHALL have port exceptions_o output 6: one-hot latched cause, same bit map as cause_i; consumed by the monitor.
REQ-010 SHALL have port cause_code_o output 3: binary index of the latched cause.
REQ-011 SHALL have port epc_o output DATA_WIDTH: latched pc_i.
REQ-012 SHALL have port tval_o output DATA_WIDTH: latched tval_i.
REQ-013 SHALL have port trap_valid_o output 1: a trap is presented.
REQ-014 SHALL have port flush_o output 1: one-cycle pulse requesting pipeline flush / PC write inhibit.
REQ-015 SHALL have port overrun_o output 1: sticky; a trap was dropped while one was pending.

Function
REQ-016 SHALL implement FSM states IDLE and PENDING.
REQ-017 SHALL, in IDLE with valid_i=1 and cause_i!=0, capture the lowest-index set bit of cause_i, plus pc_i and tval_i, and enter PENDING on the next edge.
REQ-018 SHALL ignore cause_i whenever valid_i=0.
REQ-019 SHALL, in PENDING, drive trap_valid_o=1 and hold exceptions_o, cause_code_o, epc_o and tval_o stable until acknowledged.
REQ-020 SHALL assert flush_o for exactly the first cycle of each PENDING entry (registered, 1-cycle latency from capture).
REQ-021 SHALL, in PENDING with trap_ack_i=1 and no new trap, return to IDLE, clearing exceptions_o and trap_valid_o on the next edge.
REQ-022 SHALL, in PENDING with trap_ack_i=1 and a new valid trap in the same cycle, capture the new trap and remain in PENDING (back-to-back), re-pulsing flush_o.
REQ-023 SHALL, in PENDING with trap_ack_i=0 and a new valid trap, drop it and set overrun_o.
REQ-024 SHALL clear overrun_o only by reset.
REQ-025 SHALL ignore trap_ack_i in IDLE.
REQ-026 SHALL guarantee that exceptions_o is zero or exactly one-hot at all times.

Reset
REQ-027 SHALL, on rst_i low, asynchronously force state to IDLE and all outputs to 0, including epc_o and tval_o; this holds mid-trap as well.
REQ-028 SHALL accept no capture in the first cycle after reset release.

Configuration
REQ-029 SHALL, with macro TRAP_UNIT_COUNT_EN defined, add output trap_count_o (32 bits): count of accepted traps, saturating at 0xFFFFFFFF, reset to 0, excluding dropped traps.
REQ-030 SHALL, without TRAP_UNIT_COUNT_EN, omit the port and counter entirely.

Structure
REQ-031 SHALL place the cause-index localparams (FETCH_ERR=0..EBREAK=5), NUM_CAUSES=6 and the FSM state enum in shared package trap_pkg, which the monitor also imports.
REQ-032 SHALL implement the priority select in sub-module trap_prio_enc (6-bit in, one-hot out, 3-bit index out, any-valid flag).

Verification
REQ-033 SHALL verify: valid_i=1, cause_i=6'b100000 (EBREAK), pc_i=0x80000010 -> next cycle exceptions_o=6'b100000, cause_code_o=5, epc_o=0x80000010, flush_o=1 for one cycle.
REQ-034 SHALL verify: cause_i=6'b010100 -> cause_code_o=2 (mem error wins over ECALL).
REQ-035 SHALL verify: trap pending, no ack, second trap at pc 0x80000020 -> epc_o unchanged and overrun_o=1.
REQ-036 SHALL verify: ack and new ECALL in the same cycle -> PENDING retained, cause_code_o=4, second flush_o pulse.
REQ-037 SHALL verify: cause_i=6'b000001 with valid_i=0 -> no capture, trap_valid_o stays 0.
REQ-038 SHALL verify: rst_i low mid-PENDING -> all outputs 0 immediately, without waiting for a clock edge; with TRAP_UNIT_COUNT_EN, trap_count_o=0.

Source files
------------

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared trap definitions: cause bit indices, cause count,
//                cause-code width and the trap FSM state encoding. Imported
//                by the trap unit, its priority encoder and the monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package trap_pkg;

    // Bit positions of the raw trap flags; lower index wins on collision.
    localparam int FETCH_ERR   = 0;
    localparam int DECODE_ERR  = 1;
    localparam int MEM_ERR     = 2;
    localparam int BRANCH_ERR  = 3;
    localparam int ECALL       = 4;
    localparam int EBREAK      = 5;

    localparam int NUM_CAUSES  = 6;
    localparam int CODE_W      = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } trap_state_e;

endpackage : trap_pkg
`default_nettype wire

// File: rtl/trap_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : trap_prio_enc
//  Description : Fixed-priority select of the raw trap flags. The lowest set
//                bit wins; produces its one-hot mask, binary index and an
//                any-set flag. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [NUM_CAUSES-1:0] req_i,
    output logic [NUM_CAUSES-1:0] onehot_o,
    output logic [CODE_W-1:0]     index_o,
    output logic                  any_o
);

    // Scan from the top down so the last hit (lowest index) overrides.
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                index_o     = CODE_W'(i);
            end
        end
        any_o = |req_i;
    end

endmodule : trap_prio_enc
`default_nettype wire

// File: rtl/trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : trap_unit
//  Description : Commit-stage trap latch. Captures the highest-priority trap
//                with its PC and tval, presents it to the monitor until it is
//                acknowledged, pulses a pipeline flush on each capture and
//                flags traps dropped while one is pending (sticky overrun).
//                Optional macro TRAP_UNIT_COUNT_EN adds a saturating 32-bit
//                count of accepted traps on trap_count_o.
//  Revision    : 1.0  initial release
// ============================================================================
module trap_unit
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [NUM_CAUSES-1:0] cause_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] tval_i,
    input  logic                  trap_ack_i,
    output logic [NUM_CAUSES-1:0] exceptions_o,
    output logic [CODE_W-1:0]     cause_code_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic [DATA_WIDTH-1:0] tval_o,
    output logic                  trap_valid_o,
    output logic                  flush_o,
    output logic                  overrun_o
`ifdef TRAP_UNIT_COUNT_EN
    ,
    output logic [31:0]           trap_count_o
`endif
);

    trap_state_e           state_q, state_d;
    logic [NUM_CAUSES-1:0] exc_q, exc_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] tval_q, tval_d;
    logic                  flush_q, flush_d;
    logic                  ovr_q, ovr_d;
    logic                  armed_q;

    logic [NUM_CAUSES-1:0] enc_onehot;
    logic [CODE_W-1:0]     enc_index;
    logic                  enc_any;
    logic                  new_trap;
    logic                  accept;

    trap_prio_enc u_prio_enc (
        .req_i    (cause_i),
        .onehot_o (enc_onehot),
        .index_o  (enc_index),
        .any_o    (enc_any)
    );

    // A trap is only seen with valid_i, and never in the first cycle after reset.
    assign new_trap = armed_q & valid_i & enc_any;

    // Next-state and capture logic for the IDLE/PENDING handshake.
    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        code_d  = code_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        flush_d = 1'b0;
        ovr_d   = ovr_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = new_trap;
            end
            ST_PENDING: begin
                if (trap_ack_i) begin
                    accept = new_trap;
                    if (!new_trap) begin
                        state_d = ST_IDLE;
                        exc_d   = '0;
                        code_d  = '0;
                    end
                end else if (new_trap) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_PENDING;
            exc_d   = enc_onehot;
            code_d  = enc_index;
            epc_d   = pc_i;
            tval_d  = tval_i;
            flush_d = 1'b1;
        end
    end

    // State and latched trap registers; everything clears on reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            exc_q   <= '0;
            code_q  <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            flush_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            flush_q <= flush_d;
            ovr_q   <= ovr_d;
        end
    end

    // Arms capture one edge after reset release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

`ifdef TRAP_UNIT_COUNT_EN
    logic [31:0] count_q;

    // Saturating count of accepted (not dropped) traps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (accept && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign trap_count_o = count_q;
`endif

    assign exceptions_o = exc_q;
    assign cause_code_o = code_q;
    assign epc_o        = epc_q;
    assign tval_o       = tval_q;
    assign trap_valid_o = (state_q == ST_PENDING);
    assign flush_o      = flush_q;
    assign overrun_o    = ovr_q;

endmodule : trap_unit
`default_nettype wire

// File: tb/tb_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_unit
//  Description : Self-checking bench for trap_unit: directed scenarios plus
//                randomized traffic checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_unit;

    localparam int DW = 64;

    logic          clk_i      = 1'b0;
    logic          rst_i      = 1'b0;
    logic          valid_i    = 1'b0;
    logic [5:0]    cause_i    = '0;
    logic [DW-1:0] pc_i       = '0;
    logic [DW-1:0] tval_i     = '0;
    logic          trap_ack_i = 1'b0;
    logic [5:0]    exceptions_o;
    logic [2:0]    cause_code_o;
    logic [DW-1:0] epc_o;
    logic [DW-1:0] tval_o;
    logic          trap_valid_o;
    logic          flush_o;
    logic          overrun_o;
    logic [31:0]   cnt_obs;
`ifdef TRAP_UNIT_COUNT_EN
    logic [31:0]   trap_count_o;
    assign cnt_obs = trap_count_o;
`else
    assign cnt_obs = '0;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit            m_ready;
    bit            m_pend;
    logic [5:0]    m_exc;
    logic [2:0]    m_code;
    logic [DW-1:0] m_epc;
    logic [DW-1:0] m_tval;
    bit            m_flush;
    bit            m_ovr;
    logic [31:0]   m_cnt;

    trap_unit #(.DATA_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .cause_i      (cause_i),
        .pc_i         (pc_i),
        .tval_i       (tval_i),
        .trap_ack_i   (trap_ack_i),
        .exceptions_o (exceptions_o),
        .cause_code_o (cause_code_o),
        .epc_o        (epc_o),
        .tval_o       (tval_o),
        .trap_valid_o (trap_valid_o),
        .flush_o      (flush_o),
        .overrun_o    (overrun_o)
`ifdef TRAP_UNIT_COUNT_EN
        ,
        .trap_count_o (trap_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_ready = 0; m_pend = 0; m_exc = '0; m_code = '0;
        m_epc = '0; m_tval = '0; m_flush = 0; m_ovr = 0; m_cnt = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input bit v, input logic [5:0] c, input logic [DW-1:0] pc,
                        input logic [DW-1:0] tv, input bit ack);
        bit            acc;
        bit            n_pend, n_flush, n_ovr;
        logic [5:0]    n_exc, oh;
        logic [2:0]    n_code;
        logic [DW-1:0] n_epc, n_tval;
        logic [31:0]   n_cnt;
        valid_i = v; cause_i = c; pc_i = pc; tval_i = tv; trap_ack_i = ack;
        n_pend = m_pend; n_exc = m_exc; n_code = m_code; n_epc = m_epc;
        n_tval = m_tval; n_flush = 0; n_ovr = m_ovr; n_cnt = m_cnt;
        acc = m_ready && v && (c != 0) && (!m_pend || ack);
        if (acc) begin
            oh      = c & (~c + 6'd1);      // isolate lowest set bit
            n_exc   = oh;
            n_code  = 3'($clog2(oh));
            n_epc   = pc;
            n_tval  = tv;
            n_pend  = 1;
            n_flush = 1;
            if (m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
        end else if (m_pend && ack) begin
            n_pend = 0; n_exc = '0; n_code = '0;
        end else if (m_pend && v && (c != 0)) begin
            n_ovr = 1;
        end
        @(posedge clk_i);
        m_ready = 1; m_pend = n_pend; m_exc = n_exc; m_code = n_code;
        m_epc = n_epc; m_tval = n_tval; m_flush = n_flush; m_ovr = n_ovr; m_cnt = n_cnt;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({exceptions_o, cause_code_o, trap_valid_o, flush_o, overrun_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got exc=%b code=%0d tv=%b fl=%b ov=%b, want all 0",
                     exceptions_o, cause_code_o, trap_valid_o, flush_o, overrun_o);
        end
        checks++;
        if (epc_o !== '0 || tval_o !== '0 || cnt_obs !== '0) begin
            errors++;
            $display("FAIL reset_data: got epc=%h tval=%h cnt=%0d, want 0", epc_o, tval_o, cnt_obs);
        end
        rst_i = 1'b1;
        step(1, 6'b000001, 64'h1000, 64'h1, 0);
        checks++;
        if (trap_valid_o !== 1'b0 || exceptions_o !== 6'b0) begin
            errors++;
            $display("FAIL reset_guard: got tv=%b exc=%b, want 0/000000", trap_valid_o, exceptions_o);
        end
        step(0, 6'b0, 64'h0, 64'h0, 0);
    endtask

    task automatic test_valid_low();
        repeat (2) begin
            step(0, 6'b000001, 64'h2000, 64'h2, 0);
            checks++;
            if (trap_valid_o !== 1'b0 || exceptions_o !== 6'b0) begin
                errors++;
                $display("FAIL valid_low: got tv=%b exc=%b, want 0/000000", trap_valid_o, exceptions_o);
            end
        end
    endtask

    task automatic test_ebreak();
        step(1, 6'b100000, 64'h8000_0010, 64'hDEAD_BEEF, 0);
        checks++;
        if (exceptions_o !== 6'b100000 || cause_code_o !== 3'd5 || trap_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ebreak_cause: got exc=%b code=%0d tv=%b, want 100000/5/1",
                     exceptions_o, cause_code_o, trap_valid_o);
        end
        checks++;
        if (epc_o !== 64'h8000_0010 || tval_o !== 64'hDEAD_BEEF || flush_o !== 1'b1) begin
            errors++;
            $display("FAIL ebreak_data: got epc=%h tval=%h fl=%b, want 80000010/deadbeef/1",
                     epc_o, tval_o, flush_o);
        end
        step(0, 6'b0, 64'h0, 64'h0, 0);
        checks++;
        if (flush_o !== 1'b0 || exceptions_o !== 6'b100000 || epc_o !== 64'h8000_0010) begin
            errors++;
            $display("FAIL ebreak_hold: got fl=%b exc=%b epc=%h, want 0/100000/80000010",
                     flush_o, exceptions_o, epc_o);
        end
        step(0, 6'b0, 64'h0, 64'h0, 1);
        checks++;
        if (trap_valid_o !== 1'b0 || exceptions_o !== 6'b0) begin
            errors++;
            $display("FAIL ebreak_ack: got tv=%b exc=%b, want 0/000000", trap_valid_o, exceptions_o);
        end
    endtask

    task automatic test_priority();
        step(1, 6'b010100, 64'h3000, 64'h3, 0);
        checks++;
        if (cause_code_o !== 3'd2 || exceptions_o !== 6'b000100) begin
            errors++;
            $display("FAIL priority: got code=%0d exc=%b, want 2/000100", cause_code_o, exceptions_o);
        end
        step(0, 6'b0, 64'h0, 64'h0, 1);
    endtask

    task automatic test_back_to_back();
        step(1, 6'b000010, 64'h4000, 64'h4, 0);
        step(0, 6'b0, 64'h0, 64'h0, 0);
        checks++;
        if (flush_o !== 1'b0 || cause_code_o !== 3'd1) begin
            errors++;
            $display("FAIL b2b_first: got fl=%b code=%0d, want 0/1", flush_o, cause_code_o);
        end
        step(1, 6'b010000, 64'h4100, 64'h41, 1);
        checks++;
        if (trap_valid_o !== 1'b1 || cause_code_o !== 3'd4 || flush_o !== 1'b1 || epc_o !== 64'h4100) begin
            errors++;
            $display("FAIL b2b_second: got tv=%b code=%0d fl=%b epc=%h, want 1/4/1/4100",
                     trap_valid_o, cause_code_o, flush_o, epc_o);
        end
        step(0, 6'b0, 64'h0, 64'h0, 1);
        checks++;
        if (trap_valid_o !== 1'b0 || flush_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: got tv=%b fl=%b ov=%b, want 0/0/0", trap_valid_o, flush_o, overrun_o);
        end
    endtask

    task automatic test_overrun();
        step(1, 6'b000001, 64'h8000_0010, 64'h5, 0);
        step(1, 6'b001000, 64'h8000_0020, 64'h6, 0);
        checks++;
        if (epc_o !== 64'h8000_0010 || cause_code_o !== 3'd0 || overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun: got epc=%h code=%0d ov=%b, want 80000010/0/1",
                     epc_o, cause_code_o, overrun_o);
        end
        step(0, 6'b0, 64'h0, 64'h0, 1);
        step(0, 6'b0, 64'h0, 64'h0, 0);
        checks++;
        if (overrun_o !== 1'b1 || trap_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got ov=%b tv=%b, want 1/0", overrun_o, trap_valid_o);
        end
    endtask

    task automatic test_async_reset();
        step(1, 6'b000100, 64'h9000, 64'h9, 0);
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({exceptions_o, cause_code_o, trap_valid_o, flush_o, overrun_o} !== '0 ||
            epc_o !== '0 || tval_o !== '0 || cnt_obs !== '0) begin
            errors++;
            $display("FAIL async_reset: got exc=%b code=%0d tv=%b fl=%b ov=%b epc=%h tval=%h cnt=%0d, want all 0",
                     exceptions_o, cause_code_o, trap_valid_o, flush_o, overrun_o, epc_o, tval_o, cnt_obs);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        model_reset();
        step(0, 6'b0, 64'h0, 64'h0, 0);
    endtask

    task automatic test_random();
        logic [5:0]    c;
        logic [DW-1:0] pc, tv;
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'($urandom_range(1, 63));
            pc = {$urandom, $urandom};
            tv = {$urandom, $urandom};
            step(bit'($urandom_range(0, 1)), c, pc, tv, ($urandom_range(0, 2) == 0));
            checks++;
            if (exceptions_o !== m_exc || cause_code_o !== m_code || trap_valid_o !== m_pend ||
                flush_o !== m_flush || overrun_o !== m_ovr) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: got exc=%b code=%0d tv=%b fl=%b ov=%b, want %b/%0d/%b/%b/%b",
                         n, exceptions_o, cause_code_o, trap_valid_o, flush_o, overrun_o,
                         m_exc, m_code, m_pend, m_flush, m_ovr);
            end
            if (m_pend) begin
                checks++;
                if (epc_o !== m_epc || tval_o !== m_tval) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got epc=%h tval=%h, want %h/%h", n, epc_o, tval_o, m_epc, m_tval);
                end
            end
            checks++;
            if ($countones(exceptions_o) > 1) begin
                errors++;
                $display("FAIL rand_onehot[%0d]: got exc=%b, want zero or one-hot", n, exceptions_o);
            end
`ifdef TRAP_UNIT_COUNT_EN
            checks++;
            if (trap_count_o !== m_cnt) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d, want %0d", n, trap_count_o, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_valid_low();
        test_ebreak();
        test_priority();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_trap_unit
`default_nettype wire
